// File: rtl/hd44780_text_buffer.sv
// rtl/hd44780_text_buffer.sv - 4x20 character frame store with control-byte decode and refresh trigger for the HD44780 driver
module hd44780_text_buffer #(
    parameter int          LINE_WIDTH  = 20,
    parameter int          LINES       = 4,
    parameter int          HOLDOFF     = 64,
    parameter int          ACK_TIMEOUT = 16,
    parameter logic [7:0]  FILL_CHAR   = 8'h20,
    localparam int         MEM_DEPTH   = LINE_WIDTH * LINES,
    localparam int         ADDR_W      = $clog2(MEM_DEPTH),
    localparam int         LINE_W      = $clog2(LINES),
    localparam int         COL_W       = $clog2(LINE_WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_char,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    input  logic              lcd_busy,
    output logic              trg,
    output logic [LINE_W-1:0] cur_line,
    output logic [COL_W-1:0]  cur_col,
    output logic              dirty
);
    localparam int         HOLD_W   = $clog2(HOLDOFF + 1);
    localparam int         ACK_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [7:0] CH_CLEAR = 8'h0C;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    typedef enum logic [2:0] {S_FILL, S_IDLE, S_HOLD, S_TRIG, S_ACK, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [7:0]        mem [MEM_DEPTH];
    logic [ADDR_W-1:0] fill_addr, wr_idx, mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [HOLD_W-1:0] hold_cnt;
    logic [ACK_W-1:0]  ack_cnt;
    logic              accept, is_clear, is_lf, is_cr, is_store;
    logic              fill_last, ack_expired, hold_done;
    logic [LINE_W-1:0] line_inc;

    assign wr_ready    = (state != S_FILL);
    assign trg         = (state == S_TRIG);
    assign accept      = wr_valid && wr_ready;
    assign is_clear    = accept && (wr_char == CH_CLEAR);
    assign is_lf       = accept && (wr_char == CH_LF);
    assign is_cr       = accept && (wr_char == CH_CR);
    assign is_store    = accept && (wr_char != CH_CLEAR) && (wr_char != CH_LF) && (wr_char != CH_CR);
    assign fill_last   = (fill_addr == ADDR_W'(MEM_DEPTH - 1));
    assign ack_expired = (ack_cnt == ACK_W'(ACK_TIMEOUT - 1));
    assign hold_done   = (hold_cnt == HOLD_W'(HOLDOFF));
    assign line_inc    = (cur_line == LINE_W'(LINES - 1)) ? '0 : cur_line + LINE_W'(1);
    // Linear cell index from the line/column counters; multiply by a constant, no divider.
    assign wr_idx      = ADDR_W'(cur_line) * ADDR_W'(LINE_WIDTH) + ADDR_W'(cur_col);

    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL: if (fill_last) state_nxt = S_IDLE;
            S_IDLE: if (dirty) state_nxt = S_HOLD;
            S_HOLD: if (hold_done && !lcd_busy && !accept) state_nxt = S_TRIG;
            S_TRIG: state_nxt = S_ACK;
            S_ACK: begin
                if (lcd_busy)         state_nxt = S_DONE;
                else if (ack_expired) state_nxt = S_IDLE;
            end
            S_DONE: if (!lcd_busy) state_nxt = S_IDLE;
            default: state_nxt = S_FILL;
        endcase
        if (is_clear) state_nxt = S_FILL;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = wr_idx;
        mem_wdata = wr_char;
        if (state == S_FILL) begin
            mem_we    = 1'b1;
            mem_addr  = fill_addr;
            mem_wdata = FILL_CHAR;
        end else if (is_store) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // Read-first: a same-edge write is seen only on the following read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                rd_data <= 8'h00;
        else if (rd_addr < ADDR_W'(MEM_DEPTH))   rd_data <= mem[rd_addr];
        else                                     rd_data <= FILL_CHAR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FILL;
            fill_addr <= '0;
            hold_cnt  <= '0;
            ack_cnt   <= '0;
            dirty     <= 1'b1;
            cur_line  <= '0;
            cur_col   <= '0;
        end else begin
            state     <= state_nxt;
            fill_addr <= (state == S_FILL && !fill_last) ? fill_addr + ADDR_W'(1) : '0;
            ack_cnt   <= (state == S_ACK) ? ack_cnt + ACK_W'(1) : '0;
            if (accept || state != S_HOLD) hold_cnt <= '0;
            else if (!hold_done)           hold_cnt <= hold_cnt + HOLD_W'(1);

            // An accept in the trigger cycle keeps dirty set so the new content is not lost.
            if (accept)                                       dirty <= 1'b1;
            else if (state == S_FILL && fill_last)            dirty <= 1'b1;
            else if (state == S_TRIG)                         dirty <= 1'b0;
            else if (state == S_ACK && !lcd_busy && ack_expired) dirty <= 1'b1;

            if (is_clear || is_lf || is_cr) cur_col <= '0;
            if (is_clear) begin
                cur_line <= '0;
            end else if (is_lf) begin
                cur_line <= line_inc;
            end else if (is_store) begin
                if (cur_col == COL_W'(LINE_WIDTH - 1)) begin
                    cur_col  <= '0;
                    cur_line <= line_inc;
                end else begin
                    cur_col  <= cur_col + COL_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_hd44780_text_buffer.sv
// tb/tb_hd44780_text_buffer.sv - directed table-driven bench for hd44780_text_buffer
module tb_hd44780_text_buffer;
    localparam int HOLDOFF     = 64;
    localparam int ACK_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_char = 8'h00;
    logic [6:0] rd_addr = 7'd0;
    logic [7:0] rd_data;
    logic       lcd_busy;
    logic       trg;
    logic [1:0] cur_line;
    logic [4:0] cur_col;
    logic       dirty;

    logic busy_man = 1'b0;
    logic auto_en  = 1'b1;
    int   busy_timer = 0;
    int   cyc = 0;
    int   trg_cnt = 0;
    int   trg_cyc = -1;
    int   trg_in_fill = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   last_acc = 0;

    typedef struct {
        logic [7:0] ch;
        int         line;
        int         col;
        int         addr;
    } vec_t;

    assign lcd_busy = busy_man || (busy_timer != 0);

    hd44780_text_buffer dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_char  (wr_char),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .lcd_busy (lcd_busy),
        .trg      (trg),
        .cur_line (cur_line),
        .cur_col  (cur_col),
        .dirty    (dirty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Driver stand-in: optionally answers each trg with a short busy pulse.
    always @(negedge clk) begin
        if (trg) begin
            trg_cnt <= trg_cnt + 1;
            trg_cyc <= cyc;
            if (!wr_ready) trg_in_fill <= trg_in_fill + 1;
        end
        if (auto_en && trg)      busy_timer <= 5;
        else if (busy_timer != 0) busy_timer <= busy_timer - 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] ch);
        int guard = 0;
        while (!wr_ready && guard < 200) begin
            guard++;
            tick();
        end
        if (!wr_ready) check("send_ready_timeout", 0, 1);
        wr_valid = 1'b1;
        wr_char  = ch;
        tick();
        wr_valid = 1'b0;
        last_acc = cyc;
    endtask

    task automatic measure_fill(output int n);
        n = 0;
        while (!wr_ready && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic check_fill(input string name);
        int errs = 0;
        for (int a = 0; a < 80; a++) begin
            rd_addr = 7'(a);
            tick();
            if (rd_data != 8'h20) errs++;
        end
        check(name, errs, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        int   n, base, tc, c, b, guard;

        tbl[0]  = '{8'h41, 0, 1, 0};
        tbl[1]  = '{8'h42, 0, 2, 1};
        tbl[2]  = '{8'h0D, 0, 0, -1};
        tbl[3]  = '{8'h43, 0, 1, 0};
        tbl[4]  = '{8'h0A, 1, 0, -1};
        tbl[5]  = '{8'h44, 1, 1, 20};
        tbl[6]  = '{8'h0A, 2, 0, -1};
        tbl[7]  = '{8'h0A, 3, 0, -1};
        tbl[8]  = '{8'h45, 3, 1, 60};
        tbl[9]  = '{8'h0A, 0, 0, -1};
        tbl[10] = '{8'h0D, 0, 0, -1};
        tbl[11] = '{8'h46, 0, 1, 0};

        tick();
        tick();
        check("rst_wr_ready", wr_ready, 0);
        check("rst_trg", trg, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_cur_line", cur_line, 0);
        check("rst_cur_col", cur_col, 0);
        check("rst_dirty", dirty, 1);

        rst  = 1'b1;
        base = cyc;
        measure_fill(n);
        check("powerup_fill_len", n, 80);
        check_fill("powerup_cells");
        rd_addr = 7'd100;
        tick();
        check("rd_out_of_range", rd_data, 8'h20);
        repeat (20) tick();
        check("powerup_trg_cnt", trg_cnt, 1);
        check("powerup_trg_cyc", trg_cyc - base, 81 + HOLDOFF + 1);
        check("powerup_dirty_cleared", dirty, 0);

        tc = trg_cnt;
        for (int i = 0; i < 12; i++) begin
            send_byte(tbl[i].ch);
            check($sformatf("vec%0d_line", i), cur_line, tbl[i].line);
            check($sformatf("vec%0d_col", i), cur_col, tbl[i].col);
            if (tbl[i].addr >= 0) begin
                rd_addr = 7'(tbl[i].addr);
                tick();
                check($sformatf("vec%0d_mem", i), rd_data, tbl[i].ch);
            end
        end
        repeat (100) tick();
        check("burst_single_trg", trg_cnt, tc + 1);
        check("burst_trg_delay", trg_cyc - last_acc, HOLDOFF + 1);

        send_byte(8'h57);
        repeat (3) tick();
        send_byte(8'h0C);
        measure_fill(n);
        check("clear_fill_len", n, 80);
        check("clear_line", cur_line, 0);
        check("clear_col", cur_col, 0);
        check_fill("clear_cells");

        for (int i = 0; i < 19; i++) send_byte(8'h61);
        check("wrap19_col", cur_col, 19);
        send_byte(8'h0A);
        check("wrap_lf_line", cur_line, 1);
        check("wrap_lf_col", cur_col, 0);
        repeat (3) send_byte(8'h0A);
        check("lf_from_line3", cur_line, 0);
        for (int i = 0; i < 80; i++) send_byte(8'(8'h30 + i));
        check("wrap80_line", cur_line, 0);
        check("wrap80_col", cur_col, 0);
        rd_addr = 7'd79;
        tick();
        check("wrap_addr79", rd_data, 8'h7F);
        rd_addr = 7'd19;
        tick();
        check("wrap_addr19", rd_data, 8'h43);
        rd_addr = 7'd0;
        tick();
        check("wrap_addr0", rd_data, 8'h30);
        repeat (150) tick();

        auto_en  = 1'b0;
        busy_man = 1'b1;
        tc = trg_cnt;
        send_byte(8'h5A);
        repeat (150) tick();
        check("busy_no_trg", trg_cnt, tc);
        check("busy_dirty_held", dirty, 1);
        c = cyc;
        busy_man = 1'b0;
        tick();
        tick();
        check("busy_drop_trg_cnt", trg_cnt, tc + 1);
        check("busy_drop_trg_cyc", trg_cyc - c, 1);
        auto_en = 1'b1;
        repeat (100) tick();
        check("retry_trg_cnt", trg_cnt, tc + 2);
        check("retry_trg_delay", trg_cyc - (c + 1), ACK_TIMEOUT + HOLDOFF + 3);
        check("retry_dirty_cleared", dirty, 0);

        send_byte(8'h0C);
        measure_fill(n);
        repeat (100) tick();
        auto_en = 1'b0;
        tc = trg_cnt;
        for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i));
        guard = 0;
        while (trg_cnt == tc && guard < 100) begin
            guard++;
            tick();
        end
        busy_man = 1'b1;
        check("done_trg_seen", trg_cnt, tc + 1);
        repeat (3) tick();
        check("done_dirty_cleared", dirty, 0);
        rd_addr = 7'd5;
        send_byte(8'h58);
        check("done_read_first", rd_data, 8'h20);
        tick();
        check("done_read_new", rd_data, 8'h58);
        check("done_dirty_set", dirty, 1);
        check("done_col", cur_col, 6);
        auto_en = 1'b1;
        b = cyc;
        busy_man = 1'b0;
        repeat (100) tick();
        check("done_second_trg", trg_cnt, tc + 2);
        check("done_second_delay", trg_cyc - b, 1 + 1 + HOLDOFF + 1);

        send_byte(8'h0C);
        repeat (30) tick();
        rst = 1'b0;
        tick();
        check("midfill_rst_wr_ready", wr_ready, 0);
        check("midfill_rst_rd_data", rd_data, 0);
        check("midfill_rst_dirty", dirty, 1);
        check("midfill_rst_line", cur_line, 0);
        rst = 1'b1;
        measure_fill(n);
        check("midfill_refill_len", n, 80);
        check_fill("midfill_cells");
        check("no_trg_in_fill", trg_in_fill, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
